// File: rtl/aes_cipher_unpacker.sv
// Buffers 128-bit cipher blocks in a DEPTH-entry FIFO and streams each one out as four 32-bit words.
// Define AES_UNPACK_LSW_FIRST_EN to emit [31:0] first; the default order is MSW first.
module aes_cipher_unpacker #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [127:0]             cipher_in,
  input  logic                     cipher_valid,
  output logic [31:0]              word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     word_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [127:0]         mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [1:0]           widx;
  logic [CW-1:0]        count;
  logic                 ovf;

  logic                 full;
  logic                 xfer;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [127:0]         head;
  logic [3:0][31:0]     lane;

  assign full = (count == CW'(DEPTH));
  assign head = mem[rd_ptr];

  // lane[k] is the k-th word emitted for the head block
  for (genvar g = 0; g < 4; g++) begin : g_lane
`ifdef AES_UNPACK_LSW_FIRST_EN
    assign lane[g] = head[32*g +: 32];
`else
    assign lane[g] = head[32*(3-g) +: 32];
`endif
  end

  assign word_valid = (count != '0);
  assign word_last  = word_valid & (widx == 2'd3);
  assign word_out   = lane[widx];
  assign fifo_count = count;
  assign overflow   = ovf;

  // A full FIFO still takes a block if the head leaves on the same edge
  always_comb begin
    xfer = word_valid & word_ready;
    pop  = xfer & (widx == 2'd3);
    push = cipher_valid & (~full | pop);
    drop = cipher_valid & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cipher_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      widx   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (xfer) widx   <= widx + 2'd1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop)           ovf <= 1'b1;
      else if (clear_ovf) ovf <= 1'b0;
    end
  end

endmodule
